// File: rtl/alu_pkg.sv
// Shared ALU constants: function codes, flag bit positions and flag width.
package alu_pkg;
  localparam int FLAGS_W = 5;
  localparam int FLAG_C  = 4;
  localparam int FLAG_L  = 3;
  localparam int FLAG_F  = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 0;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_XOR);
  endfunction
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and candidate flag values for one op.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]         alucont,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] nflags,
  output logic               legal
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             lt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = a - b;
  assign lt    = a < b;
  assign legal = op_legal(alucont);

  always_comb begin
    result = '0;
    nflags = '0;
    case (alucont)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
        result         = sum[WIDTH-1:0];
        nflags[FLAG_C] = sum[WIDTH];
        nflags[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result         = diff;
        nflags[FLAG_C] = lt;
        nflags[FLAG_L] = lt;
        nflags[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: result = '0;
    endcase
    nflags[FLAG_Z] = (result == '0);
    nflags[FLAG_N] = result[WIDTH-1];
  end
endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: one-deep valid/ready output register, flag register, sticky err.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alucont,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flags_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] flags,
  output logic               err
);
  logic [WIDTH-1:0]   core_result;
  logic [FLAGS_W-1:0] core_flags;
  logic               core_legal;
  logic               accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alucont (alucont),
    .a       (a),
    .b       (b),
    .result  (core_result),
    .nflags  (core_flags),
    .legal   (core_legal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else if (accept) begin
      // core already yields 0 for illegal codes, so result needs no special case
      out_valid <= 1'b1;
      result    <= core_result;
      if (core_legal && flags_we) flags <= core_flags;
      if (!core_legal) err <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expectations.
module tb_alu_exec;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alucont;
  logic [WIDTH-1:0] a, b;
  logic             flags_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags;
  logic             err;

  int checks = 0;
  int errors = 0;

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alucont   (alucont),
    .a         (a),
    .b         (b),
    .flags_we  (flags_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv,
                       input logic we);
    in_valid = 1'b1;
    alucont  = op;
    a        = av;
    b        = bv;
    flags_we = we;
  endtask

  // flags order {C,L,F,Z,N}
  logic [2:0]  s_op  [8] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b110, 3'b111};
  logic [15:0] s_a   [8] = '{16'h0001, 16'h0010, 16'hF0F0, 16'h00F0, 16'hAAAA, 16'h8000, 16'h8000, 16'h1234};
  logic [15:0] s_b   [8] = '{16'h0002, 16'h0001, 16'hFF00, 16'h0F00, 16'h5555, 16'h8000, 16'h0001, 16'h1234};
  logic [15:0] s_res [8] = '{16'h0003, 16'h000F, 16'hF000, 16'h0FF0, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h0000};
  logic [4:0]  s_flg [8] = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b00001, 5'b10110, 5'b00100, 5'b00010};

  initial begin
    reset = 1'b1; in_valid = 1'b0; alucont = '0; a = '0; b = '0;
    flags_we = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_flags",     32'(flags),     32'd0);
    chk("rst_err",       32'(err),       32'd0);
    reset = 1'b0;
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // signed overflow on ADD
    drive(3'b010, 16'h7FFF, 16'h0001, 1'b1); step();
    chk("add_ovf_valid", 32'(out_valid), 32'd1);
    chk("add_ovf_res",   32'(result),    32'h8000);
    chk("add_ovf_flags", 32'(flags),     32'b00101);

    drive(3'b110, 16'h0003, 16'h0005, 1'b1); step();
    chk("sub_borrow_res",   32'(result), 32'hFFFE);
    chk("sub_borrow_flags", 32'(flags),  32'b11001);

    drive(3'b010, 16'hFFFF, 16'h0001, 1'b1); step();
    chk("add_wrap_res",   32'(result), 32'h0000);
    chk("add_wrap_flags", 32'(flags),  32'b10010);

    // illegal code: result 0, flags hold, err sticky
    drive(3'b101, 16'h1234, 16'h4321, 1'b1); step();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_res",   32'(result),    32'h0000);
    chk("ill_flags", 32'(flags),     32'b10010);
    chk("ill_err",   32'(err),       32'd1);

    drive(3'b000, 16'hFFFF, 16'h00F0, 1'b0); step();
    chk("and_nowe_res",   32'(result), 32'h00F0);
    chk("and_nowe_flags", 32'(flags),  32'b10010);
    chk("and_nowe_err",   32'(err),    32'd1);

    // drain with no accept
    in_valid = 1'b0; step();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_res",   32'(result),    32'h00F0);

    // inputs without in_valid are ignored
    alucont = 3'b010; a = 16'h1111; b = 16'h2222; flags_we = 1'b1; step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_res",   32'(result),    32'h00F0);
    chk("idle_flags", 32'(flags),     32'b10010);

    // backpressure
    out_ready = 1'b0;
    drive(3'b111, 16'h00FF, 16'h0F0F, 1'b1); step();
    chk("xor_res",   32'(result), 32'h0FF0);
    chk("xor_flags", 32'(flags),  32'b00000);
    drive(3'b001, 16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      step();
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_res",      32'(result),    32'h0FF0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_accept_valid", 32'(out_valid), 32'd1);
    chk("bp_accept_res",   32'(result),    32'h5335);

    // back-to-back stream
    for (int i = 0; i < 8; i++) begin
      drive(s_op[i], s_a[i], s_b[i], 1'b1);
      step();
      chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stream%0d_res", i),   32'(result),    32'(s_res[i]));
      chk($sformatf("stream%0d_flags", i), 32'(flags),     32'(s_flg[i]));
    end

    // reset beats a simultaneous accept while a result is pending
    out_ready = 1'b0;
    drive(3'b010, 16'h0001, 16'h0001, 1'b1);
    reset = 1'b1; step();
    chk("rst2_valid",    32'(out_valid), 32'd0);
    chk("rst2_res",      32'(result),    32'd0);
    chk("rst2_flags",    32'(flags),     32'd0);
    chk("rst2_err",      32'(err),       32'd0);
    chk("rst2_in_ready", 32'(in_ready),  32'd1);
    reset = 1'b0; in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
